// File: rtl/rr_mux_reg.sv
// rr_mux_reg: N-channel to 1 multiplexer with valid/ready inputs and a single
// registered output stage. Channels are picked by a fixed select or by a
// round-robin arbiter, and the output stage can load while it drains.
module rr_mux_reg #(
   parameter int WIDTH = 8,
   parameter int N_CH  = 4,
   parameter int SEL_W = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  mode,
   input  logic [SEL_W-1:0]      sel,
   input  logic [N_CH-1:0]       in_valid,
   input  logic [N_CH*WIDTH-1:0] in_data,
   output logic [N_CH-1:0]       in_ready,
   output logic                  out_valid,
   output logic [WIDTH-1:0]      out_data,
   output logic [SEL_W-1:0]      out_ch,
   input  logic                  out_ready
);

   // Output register and arbiter state
   logic             out_valid_q;
   logic [WIDTH-1:0] out_data_q;
   logic [SEL_W-1:0] out_ch_q;
   logic [SEL_W-1:0] rr_ptr_q;
   logic [SEL_W-1:0] rr_ptr_d;

   // Arbitration results
   logic [N_CH-1:0]  grant;
   logic [SEL_W-1:0] grant_idx;
   logic             grant_any;
   logic             load_en;
   logic [WIDTH-1:0] grant_data;

   // Per-channel view of the flat input data bus
   logic [WIDTH-1:0] ch_data [N_CH];

   for (genvar gi = 0; gi < N_CH; gi++) begin : g_unpack
      assign ch_data[gi] = in_data[gi*WIDTH +: WIDTH];
   end

   // The register can take a new word when it is empty or emptying this cycle
   assign load_en = !out_valid_q || out_ready;

   // Pick at most one channel: fixed select, or first valid channel from rr_ptr
   always_comb begin
      int idx;
      grant     = '0;
      grant_idx = '0;
      grant_any = 1'b0;
      idx       = 0;
      if (!mode) begin
         // sel values beyond the last channel never match, so they grant nothing
         for (int i = 0; i < N_CH; i++) begin
            if (int'(sel) == i && in_valid[i]) begin
               grant[i]  = 1'b1;
               grant_idx = SEL_W'(i);
               grant_any = 1'b1;
            end
         end
      end else begin
         for (int k = 0; k < N_CH; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= N_CH) begin
               idx = idx - N_CH;
            end
            if (!grant_any && in_valid[idx]) begin
               grant[idx] = 1'b1;
               grant_idx  = SEL_W'(idx);
               grant_any  = 1'b1;
            end
         end
      end
   end

   // Data of the granted channel; only meaningful when grant_any is set
   always_comb begin
      grant_data = '0;
      for (int i = 0; i < N_CH; i++) begin
         if (grant[i]) begin
            grant_data = ch_data[i];
         end
      end
   end

   // Ready only when the output stage can load and the channel is granted
   always_comb begin
      in_ready = '0;
      if (!rst && load_en) begin
         in_ready = grant;
      end
   end

   // Pointer moves past the winner; wrap is explicit so N_CH < 2**SEL_W works
   always_comb begin
      rr_ptr_d = rr_ptr_q;
      if (mode && load_en && grant_any) begin
         if (int'(grant_idx) == N_CH - 1) begin
            rr_ptr_d = '0;
         end else begin
            rr_ptr_d = grant_idx + 1'b1;
         end
      end
   end

   // Output register: load on handshake, empty on drain without a new word
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_ch_q    <= '0;
         rr_ptr_q    <= '0;
      end else begin
         rr_ptr_q <= rr_ptr_d;
         if (load_en) begin
            if (grant_any) begin
               out_valid_q <= 1'b1;
               out_data_q  <= grant_data;
               out_ch_q    <= grant_idx;
            end else begin
               out_valid_q <= 1'b0;
            end
         end
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_ch    = out_ch_q;

endmodule
